seg7_refresh_display: RTL and testbench
=======================================

// Module: seg7_refresh_display
// PURPOSE
//  Downstream consumer of the 500 ms refresh tick. On each tick it samples a binary value,
//  converts it to 4-digit BCD (sequential double-dabble) and commits it to the display register.
//  It also time-multiplexes the 4-digit active-low 7-segment display at a fixed scan rate.
//  The displayed number therefore changes at most twice per second and stays stable between ticks.
// PARAMETERS
//  SCAN_DIV  100_000  clk cycles each digit stays lit (1 kHz/digit at 100 MHz); min 2
//  VAL_W     14       width of value_in (binary, unsigned)
// PORTS
//  clk         in   1      system clock; only clock domain
//  rst         in   1      synchronous, active-high reset
//  tick_500ms  in   1      single-cycle pulse from the 500 ms refresh timer
//  value_in    in   VAL_W  binary value to display; sampled only on tick_500ms
//  an          out  4      digit anodes, active-low; an[0] = units digit
//  seg         out  7      cathodes {g,f,e,d,c,b,a}, active-low
//  dp          out  1      decimal point, active-low; constant 1 (off)
//  busy        out  1      high while a sample is converting
//  overflow    out  1      last sampled value_in exceeded 9999
// BEHAVIOUR
//  Reset (rst=1 at a clk edge): an=4'b1111, seg=7'h7F, dp=1, busy=0, overflow=0, display reg=BCD 0000,
//   FSM=IDLE, digit index=0, scan counter=0. rst wins over any simultaneous tick.
//  Reset mid-CONVERT aborts the conversion. The partial result is discarded and the display shows "0".
//  All outputs are registered.
//  FSM IDLE -> CONVERT -> COMMIT -> IDLE:
//   IDLE: at the edge where tick_500ms=1, do the following:
//    - capture min(value_in, 9999);
//    - set overflow = (value_in > 9999);
//    - clear BCD scratch; set busy=1; go to CONVERT.
//   CONVERT: 14 edges, one double-dabble step each (add 3 to every BCD nibble >= 5, then shift left 1).
//    Uses a 4-bit step counter. After the 14th step, go to COMMIT.
//   COMMIT: copy scratch to display reg, busy=0, go to IDLE.
//  Latency: capture edge E0, steps E1..E14, commit E15.
//   busy reads 1 for exactly 15 cycles.
//   New digits appear from E16 on the currently scanned digit.
//  tick_500ms while busy is ignored: not queued, overflow unchanged.
//  The display reg only changes at COMMIT, so there are no torn digits.
//  value_in changes without a tick have no effect.
//  Scan: the counter counts 0..SCAN_DIV-1.
//   At wrap, the digit index increments mod 4 (3 -> 0 wrap-around).
//   an = ~(4'b0001 << index). The index runs independently of the FSM.
//  Leading-zero blanking: every digit above the most significant nonzero digit shows seg=7'h7F.
//   Its anode is still driven. Value 0 shows a single "0" in the units digit.
//  Encoding (seg hex): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 blank=7F.
//   BCD nibbles > 9 cannot occur; if they do, encode as blank.
// TESTING (bench uses SCAN_DIV=4)
//  1. rst, value_in=1234, one tick -> busy=1 for 15 cycles.
//     Then scan an/seg: 1110/19, 1101/30, 1011/24, 0111/79.
//  2. value_in=7, tick -> an=1110 seg=78; other three digits seg=7F; overflow=0.
//  3. value_in=12000, tick -> overflow=1; digits 9,9,9,9 (seg=10 on all).
//  4. tick with 1234, then tick with 5678 at E5 -> second tick ignored.
//     busy still falls after E15; display shows 1234.
//  5. rst at E7 of a conversion -> next cycle an=1111 seg=7F busy=0.
//     Then units shows "0" (seg=40), others blank.
//  6. After showing 42, change value_in to 99 with no tick for 8 scan periods -> still 42.
//     Check 3->0 index wrap and leading-zero blank on digits 2,3.

Source files
------------

// File: rtl/seg7_refresh_display.sv
// rtl/seg7_refresh_display.sv - samples a value on the 500 ms tick, converts it to BCD
// and scans it onto a 4-digit active-low 7-segment display with leading-zero blanking.
module seg7_refresh_display #(
    parameter int SCAN_DIV = 100_000,
    parameter int VAL_W    = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_500ms,
    input  logic [VAL_W-1:0] value_in,
    output logic [3:0]       an,
    output logic [6:0]       seg,
    output logic             dp,
    output logic             busy,
    output logic             overflow
);
    localparam int               CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [VAL_W-1:0] MAX_VAL  = VAL_W'(9999);

    typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_COMMIT} state_t;

    state_t           state_q, state_d;
    logic [29:0]      scr_q, scr_d;      // {bcd[15:0], bin[13:0]}
    logic [3:0]       step_q, step_d;
    logic [15:0]      disp_q, disp_d;
    logic             busy_q, busy_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             sample_ovf;
    logic [3:0]       cur_digit;
    logic             cur_blank;

    function automatic logic [29:0] dabble_step(input logic [29:0] s);
        logic [29:0] t;
        t = s;
        for (int i = 0; i < 4; i++) begin
            if (t[14+4*i +: 4] >= 4'd5)
                t[14+4*i +: 4] = t[14+4*i +: 4] + 4'd3;
        end
        return {t[28:0], 1'b0};
    endfunction

    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            scr_q   <= '0;
            step_q  <= '0;
            disp_q  <= '0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            idx_q   <= '0;
            an_q    <= 4'b1111;
            seg_q   <= 7'h7F;
        end else begin
            state_q <= state_d;
            scr_q   <= scr_d;
            step_q  <= step_d;
            disp_q  <= disp_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (tick_500ms) state_d = S_CONVERT;
            S_CONVERT: if (step_q == 4'd13) state_d = S_COMMIT;
            S_COMMIT:  state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    assign sample_ovf = (value_in > MAX_VAL);

    always_comb begin
        scr_d  = scr_q;
        step_d = step_q;
        disp_d = disp_q;
        busy_d = busy_q;
        ovf_d  = ovf_q;
        unique case (state_q)
            S_IDLE: begin
                if (tick_500ms) begin
                    ovf_d  = sample_ovf;
                    scr_d  = {16'd0, sample_ovf ? 14'd9999 : 14'(value_in)};
                    step_d = '0;
                    busy_d = 1'b1;
                end
            end
            S_CONVERT: begin
                scr_d  = dabble_step(scr_q);
                step_d = step_q + 4'd1;
            end
            S_COMMIT: begin
                disp_d = scr_q[29:14];
                busy_d = 1'b0;
            end
            default: ;
        endcase
    end

    // Scan path runs free of the FSM; blank any digit above the most significant nonzero one.
    assign cur_digit = disp_q[{idx_q, 2'b00} +: 4];
    assign cur_blank = (idx_q != 2'd0) && ((disp_q >> {idx_q, 2'b00}) == 16'd0);

    always_comb begin
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        idx_d = (cnt_q == CNT_LAST) ? idx_q + 2'd1 : idx_q;
        an_d  = ~(4'b0001 << idx_q);
        seg_d = cur_blank ? 7'h7F : seg_encode(cur_digit);
    end

    assign an       = an_q;
    assign seg      = seg_q;
    assign dp       = 1'b1;
    assign busy     = busy_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_seg7_refresh_display.sv
// tb/tb_seg7_refresh_display.sv - scoreboard bench for seg7_refresh_display
module tb_seg7_refresh_display;
    localparam int SCAN_DIV = 4;
    localparam int VAL_W    = 14;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             tick_500ms = 1'b0;
    logic [VAL_W-1:0] value_in = '0;
    logic [3:0]       an;
    logic [6:0]       seg;
    logic             dp, busy, overflow;

    seg7_refresh_display #(.SCAN_DIV(SCAN_DIV), .VAL_W(VAL_W)) dut (
        .clk(clk), .rst(rst), .tick_500ms(tick_500ms), .value_in(value_in),
        .an(an), .seg(seg), .dp(dp), .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {int val; bit ovf;} exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc = -1000;
    logic rst_edge = 1'b0;
    bit started = 0;
    int seg_tbl[10] = '{'h40, 'h79, 'h24, 'h30, 'h19, 'h12, 'h02, 'h78, 'h00, 'h10};

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_edge <= rst;
    end

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Decimal model: digit idx of val, blank when above the leading nonzero digit.
    function automatic int exp_seg(input int val, input int idx);
        int p;
        p = 1;
        for (int i = 0; i < idx; i++) p = p * 10;
        if (idx > 0 && val < p) return 'h7F;
        return seg_tbl[(val / p) % 10];
    endfunction

    int disp_exp = 0, disp_shown = 0, busy_cnt = 0, run_len = 0, prev_idx = 0;
    logic [3:0] prev_an = 4'hF;
    logic prev_busy = 1'b0;

    always @(negedge clk) begin
        int idx;
        exp_t e;
        if (rst_edge) begin
            started = 1;
            check("rst_an", an, 'hF);
            check("rst_seg", seg, 'h7F);
            check("rst_dp", dp, 1);
            check("rst_busy", busy, 0);
            check("rst_overflow", overflow, 0);
            sb.delete();
            disp_exp = 0; disp_shown = 0; busy_cnt = 0; run_len = 0;
            prev_an = 4'hF; prev_busy = 1'b0;
        end else if (started) begin
            idx = -1;
            for (int i = 0; i < 4; i++) if (an == ~(4'b0001 << i)) idx = i;
            check("an_onecold", int'(idx >= 0), 1);
            if (idx >= 0) begin
                check("seg", seg, exp_seg(disp_shown, idx));
                if (an == prev_an) run_len++;
                else begin
                    if (prev_an != 4'hF) begin
                        check("scan_run", run_len, SCAN_DIV);
                        check("scan_next", idx, (prev_idx + 1) % 4);
                    end
                    run_len = 1; prev_an = an; prev_idx = idx;
                end
            end
            check("dp", dp, 1);
            if (busy) busy_cnt++;
            if (prev_busy && !busy) begin
                check("busy_len", busy_cnt, 15);
                busy_cnt = 0;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_pop: conversion finished with no expected entry (t=%0t)", $time);
                end else begin
                    e = sb.pop_front();
                    check("overflow", overflow, int'(e.ovf));
                    disp_exp = e.val;
                end
            end
            prev_busy = busy;
            disp_shown = disp_exp;
        end
    end

    task automatic do_reset(input int n);
        @(posedge clk); #1;
        rst = 1'b1; tick_500ms = 1'b0; last_acc = -1000;
        repeat (n) @(posedge clk);
        #1; rst = 1'b0;
    endtask

    // A tick is accepted only if at least 16 edges passed since the last accepted one.
    task automatic issue_tick(input int v);
        exp_t e;
        int te;
        @(posedge clk); #1;
        tick_500ms = 1'b1; value_in = VAL_W'(v); te = cyc + 1;
        if (te - last_acc >= 16) begin
            e.val = (v > 9999) ? 9999 : v;
            e.ovf = (v > 9999);
            sb.push_back(e);
            last_acc = te;
        end
        @(posedge clk); #1;
        tick_500ms = 1'b0; value_in = VAL_W'($urandom_range(0, 16383));
    endtask

    initial begin
        do_reset(2);
        issue_tick(1234);  repeat (40) @(posedge clk);
        issue_tick(7);     repeat (40) @(posedge clk);
        issue_tick(12000); repeat (40) @(posedge clk);
        issue_tick(1234);  repeat (3) @(posedge clk);
        issue_tick(5678);  repeat (40) @(posedge clk);
        issue_tick(1234);  repeat (5) @(posedge clk);
        do_reset(1);       repeat (30) @(posedge clk);
        issue_tick(42);    repeat (20) @(posedge clk);
        #1; value_in = 14'd99;
        repeat (8 * SCAN_DIV) @(posedge clk);
        issue_tick(0);     repeat (30) @(posedge clk);
        issue_tick(9999);  repeat (30) @(posedge clk);
        issue_tick(10000); repeat (30) @(posedge clk);
        for (int k = 0; k < 60; k++) begin
            int v;
            v = (k % 3 == 0) ? $urandom_range(0, 16383) : $urandom_range(0, 120);
            issue_tick(v);
            repeat ($urandom_range(0, 25)) @(posedge clk);
            if ($urandom_range(0, 11) == 0) do_reset(1 + $urandom_range(0, 2));
        end
        repeat (60) @(posedge clk);
        check("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
